// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and default sizing for the SRAM secondary-port arbiter.
package sram_port_arbiter_pkg;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_LEN_W        = 8;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic {IDLE, BURST} state_t;
  typedef enum logic {OWN_CPU, OWN_HOST} owner_t;

endpackage

// File: rtl/sram_burst_addr_gen.sv
// Burst address/beat tracker: latches the start address, steps one word per beat
// with a wrapping low field, and flags the final beat.
module sram_burst_addr_gen
  import sram_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [63:0]       load_addr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              step,
  output logic [63:0]       addr,
  output logic              last
);

  // The wrapping window covers ADDR_W+1 byte-address bits; everything above is held.
  localparam int WRAP_W = ADDR_W + 1;
  localparam int STRIDE = DATA_W / 8;

  logic [LEN_W:0]    remaining;
  logic [WRAP_W-1:0] next_low;

  assign next_low = addr[WRAP_W-1:0] + WRAP_W'(STRIDE);
  assign last     = (remaining == (LEN_W+1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= {1'b0, load_len} + (LEN_W+1)'(1);
    end else if (step) begin
      addr      <= {addr[63:WRAP_W], next_low};
      remaining <= remaining - (LEN_W+1)'(1);
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbiter for the SRAM ext port: CPU has priority, host bursts are protected by
// a bounded starvation counter; one access issued per cycle at most.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int LEN_W        = DEF_LEN_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [63:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_cmd_valid,
  output logic              host_cmd_ready,
  input  logic              host_cmd_write,
  input  logic [63:0]       host_cmd_addr,
  input  logic [LEN_W-1:0]  host_cmd_len,
  input  logic              host_wdata_valid,
  output logic              host_wdata_ready,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_busy,
  output logic [63:0]       mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  state_t          state;
  logic            burst_write;
  logic [SC_W-1:0] starve_cnt;
  logic            tag_valid;
  owner_t          tag_owner;

  logic            host_elig;
  logic            starved;
  logic            host_issue;
  logic            cmd_accept;
  logic [63:0]     host_addr;
  logic            host_last;

  assign host_cmd_ready   = (state == IDLE);
  assign host_busy        = (state == BURST);
  assign cmd_accept       = host_cmd_valid && host_cmd_ready;
  assign host_elig        = (state == BURST) && (!burst_write || host_wdata_valid);
  assign starved          = host_elig && (starve_cnt == SC_W'(STARVE_LIMIT));
  assign cpu_gnt          = cpu_req && !starved;
  assign host_issue       = host_elig && !cpu_gnt;
  assign host_wdata_ready = host_issue && burst_write;

  assign cpu_rdata   = mem_rdata;
  assign host_rdata  = mem_rdata;
  assign cpu_rvalid  = tag_valid && (tag_owner == OWN_CPU);
  assign host_rvalid = tag_valid && (tag_owner == OWN_HOST);

  sram_burst_addr_gen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (cmd_accept),
    .load_addr ({host_cmd_addr[63:2], 2'b00}),
    .load_len  (host_cmd_len),
    .step      (host_issue),
    .addr      (host_addr),
    .last      (host_last)
  );

  always_comb begin
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wen   = cpu_wen;
      mem_ren   = !cpu_wen;
      mem_wdata = cpu_wdata;
    end else if (host_issue) begin
      mem_addr  = host_addr;
      mem_wen   = burst_write;
      mem_ren   = !burst_write;
      mem_wdata = host_wdata;
    end
  end

  // Burst FSM plus the starvation counter; the counter only moves while a host beat is waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      burst_write <= 1'b0;
      starve_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          starve_cnt <= '0;
          if (cmd_accept) begin
            burst_write <= host_cmd_write;
            state       <= BURST;
          end
        end
        BURST: begin
          if (host_issue) begin
            starve_cnt <= '0;
            if (host_last) state <= IDLE;
          end else if (host_elig && starve_cnt != SC_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + SC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-return tag routes next cycle's mem_rdata to whoever issued the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= 1'b0;
      tag_owner <= OWN_CPU;
    end else begin
      tag_valid <= (cpu_gnt && !cpu_wen) || (host_issue && !burst_write);
      tag_owner <= cpu_gnt ? OWN_CPU : OWN_HOST;
    end
  end

endmodule
